// File: rtl/ro_pair_sequencer_if.sv
// Handshake/bus bundle between the RO pair sequencer, its requester and the
// shared frequency counter.
interface ro_pair_sequencer_if #(
  parameter int N_BITS = 8,
  parameter int SEL_W  = 4
);
  logic              req;
  logic [31:0]       window_cycles;
  logic [15:0]       margin;
  logic [SEL_W-1:0]  ro_sel;
  logic              cnt_start;
  logic [31:0]       cnt_window;
  logic              cnt_done;
  logic [31:0]       cnt_value;
  logic [N_BITS-1:0] response;
  logic [N_BITS-1:0] unstable;
  logic              busy;
  logic              valid;
  logic              error;

  modport master (
    output req, window_cycles, margin, cnt_done, cnt_value,
    input  ro_sel, cnt_start, cnt_window, response, unstable, busy, valid, error
  );

  modport slave (
    input  req, window_cycles, margin, cnt_done, cnt_value,
    output ro_sel, cnt_start, cnt_window, response, unstable, busy, valid, error
  );
endinterface

// File: rtl/ro_pair_sequencer.sv
// Walks every RO pair through select/settle/count for both sides, compares the
// two counts against a margin and publishes the whole response at once.
module ro_pair_sequencer #(
  parameter int N_BITS = 8,
  parameter int SEL_W  = 4,
  parameter int SETTLE = 4
) (
  input logic                 clk_ref,
  input logic                 rst_n,
  ro_pair_sequencer_if.slave  bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_COMPARE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int PAIR_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int SET_W  = $clog2(SETTLE + 1);
  localparam logic [PAIR_W-1:0] LAST_PAIR   = PAIR_W'(N_BITS - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE - 1);

  logic [2:0]        state;
  logic [PAIR_W-1:0] pair;
  logic [PAIR_W-1:0] pair_nxt;
  logic              side;
  logic [SET_W-1:0]  settle_cnt;
  logic [32:0]       wd;
  logic              first_wait;
  logic [15:0]       margin_q;
  logic [31:0]       cap_val;
  logic [31:0]       count_a;
  logic [31:0]       count_b;
  logic [N_BITS-1:0] shadow_resp;
  logic [N_BITS-1:0] shadow_uns;
  logic [31:0]       diff;
  logic              a_gt_b;
  logic              pair_uns;

  // Subtract in the direction that cannot wrap.
  always_comb begin
    a_gt_b   = count_a > count_b;
    diff     = a_gt_b ? (count_a - count_b) : (count_b - count_a);
    pair_uns = (diff < {16'd0, margin_q}) || (count_a == count_b);
    pair_nxt = pair + 1'b1;
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pair           <= '0;
      side           <= 1'b0;
      settle_cnt     <= '0;
      wd             <= '0;
      first_wait     <= 1'b0;
      margin_q       <= '0;
      cap_val        <= '0;
      count_a        <= '0;
      count_b        <= '0;
      shadow_resp    <= '0;
      shadow_uns     <= '0;
      bus.ro_sel     <= '0;
      bus.cnt_start  <= 1'b0;
      bus.cnt_window <= '0;
      bus.response   <= '0;
      bus.unstable   <= '0;
      bus.busy       <= 1'b0;
      bus.valid      <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      bus.cnt_start <= 1'b0;
      bus.valid     <= 1'b0;
      bus.error     <= 1'b0;
      case (state)
        S_IDLE: if (bus.req) begin
          bus.cnt_window <= bus.window_cycles;
          margin_q       <= bus.margin;
          pair           <= '0;
          side           <= 1'b0;
          bus.ro_sel     <= '0;
          bus.busy       <= 1'b1;
          settle_cnt     <= '0;
          state          <= S_SELECT;
        end
        S_SELECT: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt    <= '0;
            bus.cnt_start <= 1'b1;
            // Watchdog is loaded alongside the start pulse so the timeout
            // lands exactly window+8 cycles after cnt_start.
            wd            <= {1'b0, bus.cnt_window} + 33'd8;
            state         <= S_START;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_START: begin
          wd         <= wd - 33'd1;
          first_wait <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          first_wait <= 1'b0;
          wd         <= wd - 33'd1;
          if (bus.cnt_done && !first_wait) begin
            cap_val <= bus.cnt_value;
            state   <= S_CAPTURE;
          end else if (wd == 33'd1) begin
            bus.error <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_CAPTURE: begin
          if (!side) begin
            count_a    <= cap_val;
            side       <= 1'b1;
            bus.ro_sel <= SEL_W'({pair, 1'b1});
            state      <= S_SELECT;
          end else begin
            count_b <= cap_val;
            state   <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          shadow_resp[pair] <= a_gt_b;
          shadow_uns[pair]  <= pair_uns;
          if (pair == LAST_PAIR) begin
            state <= S_DONE;
          end else begin
            pair       <= pair_nxt;
            side       <= 1'b0;
            bus.ro_sel <= SEL_W'({pair_nxt, 1'b0});
            state      <= S_SELECT;
          end
        end
        S_DONE: begin
          bus.response <= shadow_resp;
          bus.unstable <= shadow_uns;
          bus.valid    <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
